// File: rtl/hc_sr04_ranger.sv
//------------------------------------------------------------------------------
// Module      : hc_sr04_ranger
// Description : HC-SR04 ultrasonic ranging front end. Fires the sensor trigger
//               once per measurement period, times the echo pulse in whole
//               microseconds and converts it to distance in 0.01 mm units
//               (floor(echo_us * 343 / 20)) with a serial restoring divider.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               echo     - sensor echo, asynchronous to clk
//               trig     - sensor trigger (registered)
//               data_out - last valid distance, 0.01 mm units (held)
//               data_vld - one-cycle pulse when data_out updates
//               timeout  - one-cycle pulse when a measurement fails
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module hc_sr04_ranger #(
  parameter int CYC_US      = 50,
  parameter int TRIG_US     = 10,
  parameter int PERIOD_US   = 60000,
  parameter int ECHO_MAX_US = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo,
  output logic        trig,
  output logic [18:0] data_out,
  output logic        data_vld,
  output logic        timeout
);

  localparam int PRE_W  = (CYC_US > 1) ? $clog2(CYC_US) : 1;
  localparam int PER_W  = $clog2(PERIOD_US);
  localparam int ECHO_W = $clog2(ECHO_MAX_US + 1);

  localparam logic [PRE_W-1:0]  c_pre_last  = PRE_W'(CYC_US - 1);
  localparam logic [PER_W-1:0]  c_per_last  = PER_W'(PERIOD_US - 1);
  localparam logic [PER_W-1:0]  c_per_trig  = PER_W'(TRIG_US);
  localparam logic [PER_W-1:0]  c_per_tmo   = PER_W'(TRIG_US + ECHO_MAX_US);
  localparam logic [ECHO_W-1:0] c_echo_max  = ECHO_W'(ECHO_MAX_US);
  localparam logic [4:0]        c_last_step = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_CALC = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_echo_s1;
  logic                r_echo_s2;
  logic                r_echo_d;
  logic [PRE_W-1:0]    r_pre;
  logic [PER_W-1:0]    r_per;
  logic [PRE_W-1:0]    r_mpre;
  logic [ECHO_W-1:0]   r_echo_us;
  logic [4:0]          r_step;
  logic [23:0]         r_quo;
  logic [4:0]          r_rem;
  logic                r_trig;
  logic                r_vld;
  logic                r_to;
  logic [18:0]         r_data;

  logic                w_rise;
  logic                w_fall;
  logic                w_tick;
  logic                w_wrap;
  logic [PER_W-1:0]    w_per_nxt;
  logic [23:0]         w_prod;
  logic [5:0]          w_trial;
  logic                w_ge;
  logic [4:0]          w_rem_nxt;
  logic [23:0]         w_quo_nxt;
  logic                w_trig_nxt;
  logic                w_vld_nxt;
  logic                w_to_nxt;

  assign w_rise = r_echo_s2 & ~r_echo_d;
  assign w_fall = ~r_echo_s2 & r_echo_d;

  assign w_tick    = (r_pre == c_pre_last);
  assign w_wrap    = w_tick && (r_per == c_per_last);
  // Value per_us takes after this edge; lets the FSM act on the same edge the
  // counter reaches a boundary so trig is exactly TRIG_US*CYC_US cycles wide.
  assign w_per_nxt = w_wrap ? '0 : (w_tick ? r_per + PER_W'(1) : r_per);

  assign w_prod = 24'(r_echo_us) * 24'd343;

  // Restoring divide by 20: dividend shifts out of r_quo's MSB into the
  // remainder while quotient bits shift in at the LSB.
  assign w_trial   = {r_rem, r_quo[23]};
  assign w_ge      = (w_trial >= 6'd20);
  assign w_rem_nxt = w_ge ? 5'(w_trial - 6'd20) : w_trial[4:0];
  assign w_quo_nxt = {r_quo[22:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_trig  <= 1'b0;
      r_vld   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_trig  <= w_trig_nxt;
      r_vld   <= w_vld_nxt;
      r_to    <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_trig_nxt  = 1'b0;
    w_vld_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wrap) begin
          w_state_nxt = S_TRIG;
          w_trig_nxt  = 1'b1;
        end
      end
      S_TRIG: begin
        if (w_per_nxt == c_per_trig) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_trig_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_rise) begin
          w_state_nxt = S_MEAS;
        end else if (w_per_nxt == c_per_tmo) begin
          w_state_nxt = S_IDLE;
          w_to_nxt    = 1'b1;
        end
      end
      S_MEAS: begin
        // A fall on the same edge the limit is reached still counts as valid.
        if (w_fall) begin
          w_state_nxt = S_CALC;
        end else if (r_echo_us == c_echo_max) begin
          w_state_nxt = S_IDLE;
          w_to_nxt    = 1'b1;
        end
      end
      S_CALC: begin
        if (r_step == c_last_step) begin
          w_state_nxt = S_IDLE;
          w_vld_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
      r_pre     <= '0;
      r_per     <= '0;
      r_mpre    <= '0;
      r_echo_us <= '0;
      r_step    <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_data    <= '0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_pre     <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_per     <= w_per_nxt;
      case (r_state)
        S_WAIT: begin
          if (w_rise) begin
            r_echo_us <= '0;
            r_mpre    <= '0;
          end
        end
        S_MEAS: begin
          // r_echo_d is high for exactly as many MEAS cycles as the synced
          // echo was high, including the first cycle consumed by the rise.
          if (r_echo_d) begin
            if (r_mpre == c_pre_last) begin
              r_mpre    <= '0;
              r_echo_us <= r_echo_us + ECHO_W'(1);
            end else begin
              r_mpre <= r_mpre + PRE_W'(1);
            end
          end
          r_step <= '0;
        end
        S_CALC: begin
          r_step <= r_step + 5'd1;
          if (r_step == 5'd0) begin
            r_quo <= w_prod;
            r_rem <= '0;
          end else begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            if (r_step == c_last_step) begin
              r_data <= w_quo_nxt[18:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trig     = r_trig;
  assign data_out = r_data;
  assign data_vld = r_vld;
  assign timeout  = r_to;

endmodule

`default_nettype wire

// File: tb/tb_hc_sr04_ranger.sv
//------------------------------------------------------------------------------
// Module      : tb_hc_sr04_ranger
// Description : Self-checking bench for hc_sr04_ranger, run with a scaled-down
//               timebase (2 clk/us, 2500 us period, 1200 us echo limit) so
//               several full measurement periods fit in a short run.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hc_sr04_ranger;

  localparam int CYC  = 2;
  localparam int TRG  = 10;
  localparam int PER  = 2500;
  localparam int EMAX = 1200;
  localparam int PCYC = PER * CYC;
  // Echo change applied after edge X is first sampled at X+1, synchronized at
  // X+2, the fall is acted on at X+3, then 1 multiply + 24 divide edges.
  localparam int VLD_LAT = 28;

  logic        clk;
  logic        rst_n;
  logic        echo;
  logic        trig;
  logic [18:0] data_out;
  logic        data_vld;
  logic        timeout;

  typedef struct {
    int at;
    int val;
  } ev_t;

  ev_t vq[$];
  int  tq[$];
  int  n;
  int  m_data;
  int  nchk;
  int  nerr;

  hc_sr04_ranger #(
    .CYC_US      (CYC),
    .TRIG_US     (TRG),
    .PERIOD_US   (PER),
    .ECHO_MAX_US (EMAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .echo     (echo),
    .trig     (trig),
    .data_out (data_out),
    .data_vld (data_vld),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Edge count since reset release: after edge k, n == k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic int model_dist(input int high_cycles);
    return ((high_cycles / CYC) * 343) / 20;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    nchk++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (n=%0d)", nm, act, exp_v, n);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  endtask

  task automatic wait_n(input int t);
    int g;
    g = 0;
    while (n != t) begin
      @(negedge clk);
      g++;
      if (g > 3 * PCYC) begin
        nerr++;
        $display("FAIL wait_n: got n=%0d expected %0d", n, t);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $fatal(1, "bench stalled");
      end
    end
  endtask

  // Per-cycle compare against the behavioural model.
  always @(negedge clk) begin
    int exp_trig;
    int exp_v;
    int exp_t;
    if (!rst_n) begin
      chk("rst_trig", int'(trig), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_data_vld", int'(data_vld), 0);
      chk("rst_timeout", int'(timeout), 0);
    end else begin
      exp_trig = ((n >= PCYC) && ((n % PCYC) < TRG * CYC)) ? 1 : 0;
      exp_v = 0;
      exp_t = 0;
      if (vq.size() > 0 && vq[0].at == n) begin
        exp_v  = 1;
        m_data = vq[0].val;
        void'(vq.pop_front());
      end
      if (tq.size() > 0 && tq[0] == n) begin
        exp_t = 1;
        void'(tq.pop_front());
      end
      chk("trig", int'(trig), exp_trig);
      chk("data_vld", int'(data_vld), exp_v);
      chk("timeout", int'(timeout), exp_t);
      chk("data_out", int'(data_out), m_data);
    end
  end

  // Echo rises 200 us after trig falls in period p and stays high h cycles.
  task automatic do_meas(input int p, input int h, input int lit);
    int x;
    x = p * PCYC + TRG * CYC + 200 * CYC;
    wait_n(x);
    #1 echo = 1'b1;
    wait_n(x + h);
    #1 echo = 1'b0;
    vq.push_back('{at: x + h + VLD_LAT, val: model_dist(h)});
    wait_n(x + h + VLD_LAT);
    chk("lit_data_out", int'(data_out), lit);
    chk("lit_data_vld", int'(data_vld), 1);
  endtask

  initial begin
    int x;
    clk    = 1'b0;
    rst_n  = 1'b0;
    echo   = 1'b0;
    m_data = 0;
    nchk   = 0;
    nerr   = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    do_meas(1, 1000 * CYC, 17150);
    do_meas(2, CYC - 1, 0);
    do_meas(3, 75, 634);
    do_meas(4, EMAX * CYC - 1, 20562);

    // No echo at all: WAIT times out, data_out held.
    x = 5 * PCYC + (TRG + EMAX) * CYC;
    tq.push_back(x);
    wait_n(x);
    chk("lit_wait_timeout", int'(timeout), 1);
    chk("lit_hold_data", int'(data_out), 20562);

    // Echo stuck high: MEAS limit timeout, then WAIT timeout next period.
    x = 6 * PCYC + TRG * CYC + 200 * CYC;
    wait_n(x);
    #1 echo = 1'b1;
    tq.push_back(x + EMAX * CYC + 4);
    tq.push_back(7 * PCYC + (TRG + EMAX) * CYC);
    wait_n(x + EMAX * CYC + 4);
    chk("lit_meas_timeout", int'(timeout), 1);
    wait_n(7 * PCYC + (TRG + EMAX) * CYC);
    chk("lit_stuck_timeout", int'(timeout), 1);
    wait_n(7 * PCYC + 3000);
    #1 echo = 1'b0;

    // Reset in the middle of a measurement.
    x = 8 * PCYC + TRG * CYC + 200 * CYC;
    wait_n(x);
    #1 echo = 1'b1;
    wait_n(x + 500);
    #1;
    rst_n  = 1'b0;
    echo   = 1'b0;
    vq.delete();
    tq.delete();
    m_data = 0;
    repeat (5) @(negedge clk);
    chk("lit_rst_data", int'(data_out), 0);
    chk("lit_rst_trig", int'(trig), 0);
    #1 rst_n = 1'b1;
    wait_n(PCYC - 1);
    chk("lit_pre_trig", int'(trig), 0);
    wait_n(PCYC);
    chk("lit_first_trig", int'(trig), 1);
    do_meas(1, 1000 * CYC, 17150);

    repeat (10) @(negedge clk);
    finish_run();
  end

  initial begin
    #1500000;
    nerr++;
    $display("FAIL watchdog: got n=%0d expected run to end", n);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
